// File: rtl/seven_segment_pkg.sv
// Shared types, constants and blanking helpers for the seven-segment display path.
package seven_segment_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned DISP_W     = NUM_DIGITS * DIGIT_W;

    typedef logic [DIGIT_W-1:0] bcd_t;

    localparam bcd_t              BCD_MAX  = 4'd9;
    localparam logic [NUM_DIGITS-1:0] BLANK_AN = 4'b0000;

    function automatic bcd_t get_digit(input logic [DISP_W-1:0] disp, input logic [1:0] idx);
        return disp[{idx, 2'b00} +: DIGIT_W];
    endfunction

    // A digit is dark if it is not a BCD code, or if it is a leading zero (digit 0 always shows).
    function automatic logic is_blank(input logic [1:0] idx, input logic [DISP_W-1:0] disp,
                                      input logic blank_lz);
        logic lz;
        lz = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (k >= 32'(idx) && get_digit(disp, 2'(k)) != 4'h0) begin
                lz = 1'b0;
            end
        end
        return (get_digit(disp, idx) > BCD_MAX) || (blank_lz && (idx != 2'd0) && lz);
    endfunction

endpackage

// File: rtl/seven_segment_scan.sv
// Four-digit multiplexed scan controller with frame-synchronous double-buffered updates,
// leading-zero suppression and invalid-code blanking.
module seven_segment_scan
    import seven_segment_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DISP_W-1:0]     value_in,
    input  logic                  load,
    input  logic                  blank_lz,
    output bcd_t                  digit_out,
    output logic [NUM_DIGITS-1:0] an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int unsigned      CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0]  div_cnt;
    logic [1:0]        idx;
    logic [DISP_W-1:0] disp_reg;
    logic [DISP_W-1:0] pending_reg;

    logic tick_c;
    logic commit_c;
    logic blank_c;
    bcd_t nib_c;

    always_comb begin
        tick_c   = (div_cnt == CNT_LAST);
        commit_c = tick_c && (idx == 2'd3);
        nib_c    = get_digit(disp_reg, idx);
        blank_c  = is_blank(idx, disp_reg, blank_lz);
    end

    // Prescaler and digit ring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + CNT_W'(1);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Double buffer: a load on the commit edge bypasses the pending stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg    <= '0;
            pending_reg <= '0;
            pending     <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= commit_c;
            if (load) begin
                pending_reg <= value_in;
            end
            if (commit_c) begin
                if (load) begin
                    disp_reg <= value_in;
                end else if (pending) begin
                    disp_reg <= pending_reg;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Registered digit drive, one cycle behind the index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= 4'b0001;
            digit_out <= 4'h0;
        end else begin
            an        <= blank_c ? BLANK_AN : (4'b0001 << idx);
            digit_out <= blank_c ? 4'h0 : nib_c;
        end
    end

endmodule

// File: tb/tb_seven_segment_scan.sv
// Directed table-driven bench for seven_segment_scan at REFRESH_DIV=4.
module tb_seven_segment_scan;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  digit_out;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int n_tests;
    int n_fail;

    seven_segment_scan #(.REFRESH_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value_in   (value_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .digit_out  (digit_out),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        ld;
        logic [15:0] v;
        logic        blz;
        logic [3:0]  an;
        logic [3:0]  dig;
        logic        pend;
        logic        fd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int n, input logic ld, input logic [15:0] v, input logic blz,
                                input logic [3:0] e_an, input logic [3:0] e_dig,
                                input logic e_pend, input logic e_fd);
        vec_t r;
        r.n = n; r.ld = ld; r.v = v; r.blz = blz;
        r.an = e_an; r.dig = e_dig; r.pend = e_pend; r.fd = e_fd;
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_an, input logic [3:0] e_dig,
                             input logic e_pend, input logic e_fd);
        check({tag, ".an"},         16'(an),         16'(e_an));
        check({tag, ".digit_out"},  16'(digit_out),  16'(e_dig));
        check({tag, ".pending"},    16'(pending),    16'(e_pend));
        check({tag, ".frame_done"}, 16'(frame_done), 16'(e_fd));
    endtask

    // Apply inputs for one edge (load is a one-edge strobe), advance n edges total, sample on negedge.
    task automatic run_vec(input int n, input logic ld, input logic [15:0] v, input logic blz);
        value_in = v;
        blank_lz = blz;
        load     = ld;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (n - 1) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value_in = 16'h0000;
        blank_lz = 1'b0;

        // Edge counts E in comments are posedges since reset release.
        vecs.push_back(mk( 1, 0, 16'h0000, 0, 4'b0001, 4'h0, 0, 0)); // E=1
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0010, 4'h0, 0, 0)); // E=5
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0100, 4'h0, 0, 0)); // E=9
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b1000, 4'h0, 0, 0)); // E=13
        vecs.push_back(mk( 3, 0, 16'h0000, 0, 4'b1000, 4'h0, 0, 1)); // E=16 frame end
        vecs.push_back(mk( 1, 0, 16'h0000, 0, 4'b0001, 4'h0, 0, 0)); // E=17
        vecs.push_back(mk( 1, 1, 16'h1234, 0, 4'b0001, 4'h0, 1, 0)); // E=18 load mid-frame
        vecs.push_back(mk(13, 0, 16'h0000, 0, 4'b1000, 4'h0, 1, 0)); // E=31
        vecs.push_back(mk( 1, 0, 16'h0000, 0, 4'b1000, 4'h0, 0, 1)); // E=32 commit
        vecs.push_back(mk( 1, 0, 16'h0000, 0, 4'b0001, 4'h4, 0, 0)); // E=33
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0010, 4'h3, 0, 0)); // E=37
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0100, 4'h2, 0, 0)); // E=41
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b1000, 4'h1, 0, 0)); // E=45
        vecs.push_back(mk( 1, 1, 16'h0070, 1, 4'b1000, 4'h1, 1, 0)); // E=46 lz on, 1234 unaffected
        vecs.push_back(mk( 3, 0, 16'h0000, 1, 4'b0001, 4'h0, 0, 0)); // E=49 0070 digit0
        vecs.push_back(mk( 4, 0, 16'h0000, 1, 4'b0010, 4'h7, 0, 0)); // E=53
        vecs.push_back(mk( 4, 0, 16'h0000, 1, 4'b0000, 4'h0, 0, 0)); // E=57 leading zero
        vecs.push_back(mk( 4, 0, 16'h0000, 1, 4'b0000, 4'h0, 0, 0)); // E=61 leading zero
        vecs.push_back(mk( 1, 1, 16'h0000, 1, 4'b0000, 4'h0, 1, 0)); // E=62
        vecs.push_back(mk( 3, 0, 16'h0000, 1, 4'b0001, 4'h0, 0, 0)); // E=65 zero still shows
        vecs.push_back(mk( 4, 0, 16'h0000, 1, 4'b0000, 4'h0, 0, 0)); // E=69
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0100, 4'h0, 0, 0)); // E=73 lz off live
        vecs.push_back(mk( 1, 1, 16'h9A05, 0, 4'b0100, 4'h0, 1, 0)); // E=74
        vecs.push_back(mk( 7, 0, 16'h0000, 0, 4'b0001, 4'h5, 0, 0)); // E=81
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0010, 4'h0, 0, 0)); // E=85
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0000, 4'h0, 0, 0)); // E=89 invalid code A
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b1000, 4'h9, 0, 0)); // E=93
        vecs.push_back(mk( 1, 1, 16'h1111, 0, 4'b1000, 4'h9, 1, 0)); // E=94
        vecs.push_back(mk( 1, 1, 16'h2222, 0, 4'b1000, 4'h9, 1, 0)); // E=95
        vecs.push_back(mk( 1, 1, 16'h3333, 0, 4'b1000, 4'h9, 0, 1)); // E=96 load on commit
        vecs.push_back(mk( 1, 0, 16'h0000, 0, 4'b0001, 4'h3, 0, 0)); // E=97
        vecs.push_back(mk( 4, 0, 16'h0000, 0, 4'b0010, 4'h3, 0, 0)); // E=101
        vecs.push_back(mk(12, 0, 16'h0000, 0, 4'b0001, 4'h3, 0, 0)); // E=113 no stale commit
        vecs.push_back(mk( 1, 1, 16'h4567, 0, 4'b0001, 4'h3, 1, 0)); // E=114
        vecs.push_back(mk( 8, 0, 16'h0000, 0, 4'b0100, 4'h3, 1, 0)); // E=122 digit-2 slot

        repeat (3) @(posedge clk);
        check_all("in_reset", 4'b0001, 4'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        check_all("reset_release", 4'b0001, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i].n, vecs[i].ld, vecs[i].v, vecs[i].blz);
            check_all($sformatf("vec%0d", i), vecs[i].an, vecs[i].dig, vecs[i].pend, vecs[i].fd);
        end

        // Asynchronous reset mid digit-2 slot with a value pending.
        #1 rst_n = 1'b0;
        #1 check_all("async_reset", 4'b0001, 4'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(1, 0, 16'h0000, 0);
        check_all("post_reset_e1", 4'b0001, 4'h0, 0, 0);
        run_vec(4, 0, 16'h0000, 0);
        check_all("post_reset_e5", 4'b0010, 4'h0, 0, 0);
        run_vec(11, 0, 16'h0000, 0);
        check_all("post_reset_e16", 4'b1000, 4'h0, 0, 1);
        run_vec(1, 0, 16'h0000, 0);
        check_all("pending_discarded", 4'b0001, 4'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_segment_scan.md
# seven_segment_scan

Four-digit time-multiplexed scan controller that sits directly upstream of the `seven_segment_led` decoder. It holds a 16-bit packed-BCD display value and double-buffers updates so they apply only at frame boundaries. It steps through the four digits at a programmable refresh rate, presenting one 4-bit digit code to the decoder's `in` and a one-hot, active-high digit enable to its `a`. It also provides leading-zero blanking and blanks any digit holding an invalid (non-BCD) code.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is displayed; legal range ≥ 2.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `value_in`  input  16  packed BCD; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `load`  input  1  single-cycle strobe; captures `value_in` into the pending buffer.
- `blank_lz`  input  1  level; enables leading-zero suppression.
- `digit_out`  output  4  BCD code of the active digit; drives decoder `in`.
- `an`  output  4  one-hot active-high digit enable; bit k selects digit k; drives decoder `a`.
- `pending`  output  1  high while a loaded value is waiting for commit.
- `frame_done`  output  1  one-cycle pulse when digit 3's slot ends.

## Operation
- Prescaler `div_cnt` counts 0..`REFRESH_DIV`-1 and wraps. Terminal count is the `tick` condition.
- Digit index `idx` (2 bits) advances on `tick`: 0→1→2→3→0.
- Commit happens on a `tick` where `idx`==3:
  - `disp_reg` <= pending buffer if `pending`=1; `pending` clears.
  - `frame_done` pulses on the same edge.
- Load rules:
  - `load`=1 writes `pending_reg` <= `value_in` and sets `pending`.
  - A second load before commit overwrites the first; last load wins.
  - If `load` coincides with the commit cycle, `value_in` commits directly to `disp_reg` and `pending` stays 0.
- Digit blanking: digit k is blanked if either condition holds:
  - its nibble is > 9 (the decoder output is undefined for these codes);
  - `blank_lz`=1, k ≥ 1, and nibbles k..3 of `disp_reg` are all zero.
- Digit 0 is never blanked by leading-zero suppression, so value 0 shows "0".
- Output for a shown digit: `an` = 1<<idx, `digit_out` = nibble[idx].
- Output for a blanked digit: `an` = 4'b0000, `digit_out` = 4'h0.
- `blank_lz` is sampled combinationally each cycle; no latching.
- No FSM beyond the `idx` ring; `disp_reg`/`pending_reg` form the only buffering.

## Timing
- Reset values:
  - `div_cnt`=0, `idx`=0, `disp_reg`=16'h0000, `pending_reg`=16'h0000;
  - `pending`=0, `frame_done`=0, `an`=4'b0001, `digit_out`=4'h0.
- All outputs are registered.
- `an`/`digit_out` reflect the new `idx` on the edge after the `tick` edge: 1-cycle latency from the index change.
- A committed value appears on the next frame's digit 0 slot.
- Worst-case load-to-display latency: 4·`REFRESH_DIV`+1 cycles.
- `pending` rises the edge after `load`; falls on the commit edge.
- `frame_done` is high exactly 1 cycle per 4·`REFRESH_DIV` cycles.
- Reset mid-frame: all state returns to reset values immediately (asynchronous); any pending value is discarded.
- `div_cnt` width is $clog2(`REFRESH_DIV`).

## Structure
- Shared package `seven_segment_pkg`:
  - `NUM_DIGITS`=4;
  - `BCD_MAX`=4'd9;
  - `BLANK_AN`=4'b0000;
  - `typedef logic [3:0] bcd_t`.
- No sub-module inside this block. The top level instantiates `seven_segment_scan` feeding `seven_segment_led`.
- A helper function `is_blank(idx, disp_reg, blank_lz)` in the package is recommended.

## Test plan
All scenarios use `REFRESH_DIV`=4.
- Reset release, no load -> `an` sequence 0001, 0010, 0100, 1000 each held 4 cycles; `digit_out`=0 on all; `frame_done` every 16 cycles.
- `load` `value_in`=16'h1234 mid-frame -> `pending`=1 until the idx-3 `tick`; the next frame shows digits 4, 3, 2, 1 on `an` bits 0..3.
- `blank_lz`=1, value 16'h0070 -> digit 0 shows 0, digit 1 shows 7, digits 2 and 3 have `an`=0000; with value 16'h0000, only digit 0 is shown.
- Value 16'h9A05 -> digit 2 (code A) has `an`=0000 and `digit_out`=0; digits 0, 1, 3 show 5, 0, 9.
- Back-to-back loads 16'h1111 then 16'h2222 before commit, followed by a load of 16'h3333 on the commit cycle -> display goes directly to 3333 and `pending`=0 afterwards.
- Assert `rst_n`=0 mid digit-2 slot with `pending`=1 -> `an`=0001, `digit_out`=0, `pending`=0 and `disp_reg`=0 asynchronously.
